// File: rtl/cp0_reg.sv
// CP0 register file: write-back stage writes, combinational mfc0 reads,
// the Count/Compare timer and sampling of the external interrupt lines into Cause.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG  = 5'd16;

  // Cause bits software may write: IV[23], WP[22], IP[9:8].
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_timer_int;

  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_timer_hit;
  logic [31:0] w_cause_next;
  logic [31:0] w_rdata;

  assign w_wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign w_wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign w_wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign w_wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign w_wr_epc     = we_i && (waddr_i == ADDR_EPC);
  assign w_timer_hit  = (r_compare != 32'd0) && (r_count == r_compare);

  // Next Cause value: masked software write, then IP[15:10] always tracks int_i.
  always_comb begin
    w_cause_next = r_cause;
    if (w_wr_cause) begin
      w_cause_next = (r_cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    end else begin
      w_cause_next = r_cause;
    end
    w_cause_next[15:10] = int_i;
  end

  // Architectural state; a Compare write clears the timer even on a match cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_status    <= STATUS_RST;
      r_cause     <= 32'd0;
      r_epc       <= 32'd0;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= w_wr_count ? data_i : (r_count + 32'd1);
      r_cause <= w_cause_next;
      if (w_wr_compare) begin
        r_compare   <= data_i;
        r_timer_int <= 1'b0;
      end else if (w_timer_hit) begin
        r_timer_int <= 1'b1;
      end
      if (w_wr_status) begin
        r_status <= data_i;
      end
      if (w_wr_epc) begin
        r_epc <= data_i;
      end
    end
  end

  // mfc0 read mux; returns the pre-write value, forced to zero during reset.
  always_comb begin
    w_rdata = 32'd0;
    if (rst) begin
      w_rdata = 32'd0;
    end else begin
      case (raddr_i)
        ADDR_COUNT:   w_rdata = r_count;
        ADDR_COMPARE: w_rdata = r_compare;
        ADDR_STATUS:  w_rdata = r_status;
        ADDR_CAUSE:   w_rdata = r_cause;
        ADDR_EPC:     w_rdata = r_epc;
        ADDR_PRID:    w_rdata = PRID_VALUE;
        ADDR_CONFIG:  w_rdata = CONFIG_VALUE;
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  assign data_o      = w_rdata;
  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed-vector bench for cp0_reg with hand-computed expected values.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  int n_tests;
  int n_fail;

  cp0_reg dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .raddr_i     (raddr_i),
    .int_i       (int_i),
    .data_o      (data_o),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .config_o    (config_o),
    .prid_o      (prid_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we_i    = 1'b1;
    waddr_i = addr;
    data_i  = data;
    tick();
    we_i    = 1'b0;
    waddr_i = 5'd0;
    data_i  = 32'd0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    we_i    = 1'b0;
    waddr_i = 5'd0;
    data_i  = 32'd0;
    raddr_i = 5'd12;
    int_i   = 6'd0;
    #1;
    check("rst_data_o", data_o, 32'd0);
    check("rst_status", status_o, 32'h10000000);
    check("rst_count", count_o, 32'd0);
    tick();
    rst = 1'b0;

    check("count0", count_o, 32'd0);
    check("status", status_o, 32'h10000000);
    check("config", config_o, 32'h00008000);
    check("prid", prid_o, 32'h004C0102);
    check("timer0", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("count1", count_o, 32'd1);
    tick();
    check("count2", count_o, 32'd2);
    raddr_i = 5'd5;
    #1;
    check("rd_unmapped", data_o, 32'd0);

    // Count wrap
    wr(5'd9, 32'hFFFFFFFE);
    check("wrap_fe", count_o, 32'hFFFFFFFE);
    tick();
    check("wrap_ff", count_o, 32'hFFFFFFFF);
    tick();
    check("wrap_00", count_o, 32'h00000000);

    // Timer match at 0x20
    wr(5'd11, 32'h20);
    check("compare", compare_o, 32'h20);
    wr(5'd9, 32'h1C);
    check("count_1c", count_o, 32'h1C);
    tick(); tick(); tick(); tick();
    check("count_20", count_o, 32'h20);
    check("timer_pre", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("timer_rise", {31'd0, timer_int_o}, 32'd1);
    tick();
    check("timer_hold", {31'd0, timer_int_o}, 32'd1);
    wr(5'd11, 32'h40);
    check("timer_clr", {31'd0, timer_int_o}, 32'd0);

    // Compare write on the match cycle keeps the timer low
    wr(5'd9, 32'h3E);
    tick();
    check("count_3f", count_o, 32'h3F);
    tick();
    check("count_40", count_o, 32'h40);
    wr(5'd11, 32'h80);
    check("timer_race", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("timer_race2", {31'd0, timer_int_o}, 32'd0);

    // Cause masked write plus interrupt sampling
    int_i = 6'b101010;
    wr(5'd13, 32'hFFFFFFFF);
    check("cause_wr", cause_o, 32'h00C0AB00);
    int_i = 6'b000000;
    tick();
    check("cause_int", cause_o, 32'h00C00300);

    // Status, read-only and unmapped writes
    wr(5'd12, 32'h1000FF01);
    check("status_wr", status_o, 32'h1000FF01);
    wr(5'd15, 32'd0);
    wr(5'd16, 32'd0);
    wr(5'd5, 32'hDEADBEEF);
    raddr_i = 5'd15;
    #1;
    check("rd_prid", data_o, 32'h004C0102);
    raddr_i = 5'd16;
    #1;
    check("rd_config", data_o, 32'h00008000);
    raddr_i = 5'd12;
    #1;
    check("rd_status", data_o, 32'h1000FF01);

    // EPC same-cycle write/read returns the old value
    raddr_i = 5'd14;
    we_i    = 1'b1;
    waddr_i = 5'd14;
    data_i  = 32'hBFC00100;
    #1;
    check("epc_old", data_o, 32'd0);
    tick();
    we_i    = 1'b0;
    check("epc_new", data_o, 32'hBFC00100);

    // Async reset mid-count with the timer set
    wr(5'd9, 32'h4E);
    wr(5'd11, 32'h50);
    tick();
    check("count_50", count_o, 32'h50);
    tick();
    check("timer_set", {31'd0, timer_int_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", count_o, 32'd0);
    check("arst_compare", compare_o, 32'd0);
    check("arst_status", status_o, 32'h10000000);
    check("arst_cause", cause_o, 32'd0);
    check("arst_epc", epc_o, 32'd0);
    check("arst_timer", {31'd0, timer_int_o}, 32'd0);
    check("arst_data", data_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_count", count_o, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
